srt2_divider: RTL and testbench

SRT2_DIVIDER -- requirements
Module: srt2_divider

---
 rtl/srt2_divider_if.sv | 19 +
 rtl/srt2_divider.sv | 190 +++++++++++++++++++
 tb/tb_srt2_divider.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/srt2_divider_if.sv
// Request/result bundle for srt2_divider: the requester drives the master side, the divider the slave side.
interface srt2_divider_if #(
  parameter int WID = 16
);
  logic           valid;
  logic           in_ready;
  logic           signed_en;
  logic [WID-1:0] dividend;
  logic [WID-1:0] divisor;
  logic           ready;
  logic [WID-1:0] quotient;
  logic [WID-1:0] remainder;
  logic           div_zero;

  modport master (output valid, signed_en, dividend, divisor,
                  input  in_ready, ready, quotient, remainder, div_zero);
  modport slave  (input  valid, signed_en, dividend, divisor,
                  output in_ready, ready, quotient, remainder, div_zero);
endinterface

// File: rtl/srt2_divider.sv
// Radix-2 SRT divider, signed/unsigned, normalised divisor, on-the-fly quotient conversion.
// Optional zero-divisor short cut enabled by defining SRT2_DIVZERO_EN.
module srt2_divider #(
  parameter int WID = 16
) (
  input logic           clk,
  input logic           rst,
  srt2_divider_if.slave dif
);
  localparam int PW = WID + 2;
  localparam int CW = $clog2(WID + 1);

  typedef enum logic [1:0] {IDLE, WORK, CORR, DONE} state_t;
  state_t state_q, state_d;

  logic signed [PW-1:0] p_q, p_d;
  logic [WID-1:0]       dn_q, dn_d;
  logic [WID-1:0]       qa_q, qa_d, qm_q, qm_d;
  logic [CW-1:0]        lz_q, lz_d, cnt_q, cnt_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WID-1:0]       quo_q, quo_d, rem_q, rem_d;
  logic                 accept, dvd_neg, dvs_neg;
  logic [WID-1:0]       dvd_mag, dvs_mag, qf;
  logic [CW-1:0]        lz_in;
  logic signed [PW-1:0] dext, w;
  logic [1:0]           dig;
`ifdef SRT2_DIVZERO_EN
  logic                 dz_q, dz_d, dzo_q, dzo_d, dvs_zero;
`endif

  function automatic logic [WID-1:0] cond_neg(input logic [WID-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [CW-1:0] lzc(input logic [WID-1:0] x);
    logic [CW-1:0] n;
    logic          found;
    n     = CW'(WID);
    found = 1'b0;
    for (int i = WID - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = CW'(WID - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Top three bits of 2w (weights -2, 1, 1/2): >=0 -> +1, -1/2 -> 0, <=-1 -> -1.
  function automatic logic [1:0] sel_digit(input logic [2:0] top);
    case (top)
      3'b000, 3'b001, 3'b010, 3'b011: sel_digit = 2'b01;
      3'b111:                         sel_digit = 2'b00;
      default:                        sel_digit = 2'b11;
    endcase
  endfunction

  assign accept  = dif.valid && (state_q == IDLE);
  assign dvd_neg = dif.signed_en & dif.dividend[WID-1];
  assign dvs_neg = dif.signed_en & dif.divisor[WID-1];
  assign dvd_mag = cond_neg(dif.dividend, dvd_neg);
  assign dvs_mag = cond_neg(dif.divisor, dvs_neg);
  assign lz_in   = lzc(dvs_mag);
  assign dext    = $signed({2'b00, dn_q});
`ifdef SRT2_DIVZERO_EN
  assign dvs_zero = (dif.divisor == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dif.valid) begin
`ifdef SRT2_DIVZERO_EN
        state_d = dvs_zero ? CORR : WORK;
`else
        state_d = WORK;
`endif
      end
      WORK: if (cnt_q == '0) state_d = CORR;
      CORR: state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    dif.in_ready = (state_q == IDLE);
    dif.ready    = (state_q == DONE);
  end

  always_comb begin
    p_d = p_q;  dn_d = dn_q;  qa_d = qa_q;  qm_d = qm_q;
    lz_d = lz_q;  cnt_d = cnt_q;  qneg_d = qneg_q;  rneg_d = rneg_q;
    quo_d = quo_q;  rem_d = rem_q;
    w = '0;  dig = 2'b00;  qf = qa_q;
`ifdef SRT2_DIVZERO_EN
    dz_d = dz_q;  dzo_d = dzo_q;
`endif
    case (state_q)
      // IDLE: capture magnitudes; the partial remainder starts as 2*w0 = |dividend|
      IDLE: if (accept) begin
        p_d    = $signed({2'b00, dvd_mag});
        dn_d   = dvs_mag << lz_in;
        lz_d   = lz_in;
        cnt_d  = lz_in;
        qa_d   = '0;
        qm_d   = '0;
        qneg_d = dvd_neg ^ dvs_neg;
        rneg_d = dvd_neg;
`ifdef SRT2_DIVZERO_EN
        dz_d = dvs_zero;
        if (dvs_zero) p_d = $signed({2'b00, dif.dividend});
`endif
      end
      // WORK: one SRT digit per cycle, Q/QM kept modulo 2^WID
      WORK: begin
        dig = sel_digit(p_q[PW-1 -: 3]);
        case (dig)
          2'b01: begin
            w    = p_q - dext;
            qa_d = {qa_q[WID-2:0], 1'b1};
            qm_d = {qa_q[WID-2:0], 1'b0};
          end
          2'b11: begin
            w    = p_q + dext;
            qa_d = {qm_q[WID-2:0], 1'b1};
            qm_d = {qm_q[WID-2:0], 1'b0};
          end
          default: begin
            w    = p_q;
            qa_d = {qa_q[WID-2:0], 1'b0};
            qm_d = {qm_q[WID-2:0], 1'b1};
          end
        endcase
        p_d = w <<< 1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      // CORR: restore a negative remainder, denormalise, apply signs
      CORR: begin
        w = p_q >>> 1;
        if (w[PW-1]) begin
          w  = w + dext;
          qf = qm_q;
        end else begin
          qf = qa_q;
        end
        quo_d = cond_neg(qf, qneg_q);
        rem_d = cond_neg(WID'(w >>> lz_q), rneg_q);
`ifdef SRT2_DIVZERO_EN
        dzo_d = dz_q;
        if (dz_q) begin
          quo_d = '1;
          rem_d = p_q[WID-1:0];
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;  dn_q <= '0;  qa_q <= '0;  qm_q <= '0;
      lz_q <= '0;  cnt_q <= '0;  qneg_q <= 1'b0;  rneg_q <= 1'b0;
      quo_q <= '0;  rem_q <= '0;
`ifdef SRT2_DIVZERO_EN
      dz_q <= 1'b0;  dzo_q <= 1'b0;
`endif
    end else begin
      p_q <= p_d;  dn_q <= dn_d;  qa_q <= qa_d;  qm_q <= qm_d;
      lz_q <= lz_d;  cnt_q <= cnt_d;  qneg_q <= qneg_d;  rneg_q <= rneg_d;
      quo_q <= quo_d;  rem_q <= rem_d;
`ifdef SRT2_DIVZERO_EN
      dz_q <= dz_d;  dzo_q <= dzo_d;
`endif
    end
  end

  assign dif.quotient  = quo_q;
  assign dif.remainder = rem_q;
`ifdef SRT2_DIVZERO_EN
  assign dif.div_zero  = dzo_q;
`else
  assign dif.div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_srt2_divider.sv
// Randomised bench for srt2_divider (WID=8) against an integer-arithmetic reference model.
module tb_srt2_divider;
  localparam int WID = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  srt2_divider_if #(.WID(WID)) dif();
  srt2_divider #(.WID(WID)) dut (.clk(clk), .rst(rst), .dif(dif));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_lz(input logic [WID-1:0] m);
    int bl = 0;
    while (bl < WID && (m >> bl) != 0) bl++;
    return WID - bl;
  endfunction

  task automatic ref_div(input logic s, input logic [WID-1:0] a, input logic [WID-1:0] b,
                         output logic [WID-1:0] q, output logic [WID-1:0] r,
                         output logic dz, output int lat, output bit care);
    int sa, sb;
    logic [WID-1:0] mb;
    if (s) begin sa = int'($signed(a)); sb = int'($signed(b)); end
    else   begin sa = int'(a);          sb = int'(b);          end
    mb = (sb < 0) ? WID'(-sb) : WID'(sb);
    dz = 1'b0;
    care = 1'b1;
    if (sb == 0) begin
`ifdef SRT2_DIVZERO_EN
      q = '1; r = a; dz = 1'b1; lat = 2;
`else
      q = '0; r = '0; lat = WID + 3; care = 1'b0;
`endif
    end else begin
      q   = WID'(sa / sb);
      r   = WID'(sa % sb);
      lat = ref_lz(mb) + 3;
    end
  endtask

  task automatic do_op(input logic s, input logic [WID-1:0] a, input logic [WID-1:0] b, input string tag);
    logic [WID-1:0] eq, er;
    logic edz;
    int elat, k;
    bit got, care;
    ref_div(s, a, b, eq, er, edz, elat, care);
    k = 0;
    @(negedge clk);
    while (!dif.in_ready && k < 50) begin @(negedge clk); k++; end
    check({tag, "_inrdy"}, 32'(dif.in_ready), 32'd1);
    dif.valid = 1'b1; dif.signed_en = s; dif.dividend = a; dif.divisor = b;
    @(posedge clk);
    #1;
    dif.valid = 1'b0;
    dif.signed_en = 1'($urandom); dif.dividend = WID'($urandom); dif.divisor = WID'($urandom);
    k = 0; got = 1'b0;
    while (!got && k < 60) begin @(negedge clk); k++; got = dif.ready; end
    check({tag, "_lat"}, 32'(k), 32'(elat));
    if (got) begin
      if (care) begin
        check({tag, "_quo"}, 32'(dif.quotient), 32'(eq));
        check({tag, "_rem"}, 32'(dif.remainder), 32'(er));
      end
      check({tag, "_dz"}, 32'(dif.div_zero), 32'(edz));
      check({tag, "_busy"}, 32'(dif.in_ready), 32'd0);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(dif.ready), 32'd0);
      if (care) check({tag, "_hold"}, 32'(dif.quotient), 32'(eq));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen, got;
    logic s;
    logic [WID-1:0] a, b;

    rst = 1'b1;
    dif.valid = 1'b0; dif.signed_en = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_inrdy", 32'(dif.in_ready), 32'd1);
    check("rst_ready", 32'(dif.ready), 32'd0);
    check("rst_quo", 32'(dif.quotient), 32'd0);
    check("rst_rem", 32'(dif.remainder), 32'd0);
    check("rst_dz", 32'(dif.div_zero), 32'd0);

    do_op(1'b0, 8'd200, 8'd7,   "u200_7");
    do_op(1'b1, 8'hF9,  8'h02,  "s_m7_2");
    do_op(1'b1, 8'h80,  8'hFF,  "s_min_m1");
    do_op(1'b0, 8'hFF,  8'h01,  "u255_1");
    do_op(1'b1, 8'h80,  8'h01,  "s_min_1");
    do_op(1'b0, 8'h80,  8'hFF,  "u128_255");
    do_op(1'b0, 8'h00,  8'h05,  "u0_5");
    do_op(1'b1, 8'h7F,  8'h80,  "s_max_min");
    do_op(1'b0, 8'h55,  8'h00,  "zero");

    // Reset during cycle 3 of 200/7 drops the operation.
    @(negedge clk);
    dif.valid = 1'b1; dif.signed_en = 1'b0; dif.dividend = 8'd200; dif.divisor = 8'd7;
    @(posedge clk);
    #1 dif.valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (dif.ready) seen = 1'b1; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_inrdy", 32'(dif.in_ready), 32'd1);
    check("midrst_ready", 32'(dif.ready), 32'd0);
    check("midrst_quo", 32'(dif.quotient), 32'd0);
    check("midrst_rem", 32'(dif.remainder), 32'd0);
    repeat (15) begin @(negedge clk); if (dif.ready) seen = 1'b1; end
    check("midrst_noready", 32'(seen), 32'd0);

    // valid held high with changing operands: only the first request counts.
    @(negedge clk);
    dif.valid = 1'b1; dif.signed_en = 1'b0; dif.dividend = 8'd200; dif.divisor = 8'd7;
    @(posedge clk);
    k = 0; got = 1'b0;
    while (k < 60) begin
      #1;
      dif.signed_en = 1'($urandom); dif.dividend = WID'($urandom); dif.divisor = WID'($urandom);
      @(negedge clk);
      k++;
      if (dif.ready) begin got = 1'b1; break; end
      @(posedge clk);
    end
    check("held_lat", 32'(k), 32'd8);
    check("held_quo", 32'(dif.quotient), 32'd28);
    check("held_rem", 32'(dif.remainder), 32'd4);
    check("held_busy", 32'(dif.in_ready), 32'd0);
    dif.signed_en = 1'b0; dif.dividend = 8'd100; dif.divisor = 8'd9;
    @(negedge clk);
    check("held_next_inrdy", 32'(dif.in_ready), 32'd1);
    @(posedge clk);
    #1 dif.valid = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 60) begin @(negedge clk); k++; got = dif.ready; end
    check("held2_lat", 32'(k), 32'd7);
    check("held2_quo", 32'(dif.quotient), 32'd11);
    check("held2_rem", 32'(dif.remainder), 32'd1);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = WID'($urandom);
      b = ($urandom_range(0, 3) == 0) ? WID'($urandom_range(1, 3)) : WID'($urandom);
      if (b == '0) b = 8'd1;
      do_op(s, a, b, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
